// File: rtl/instr_loader.sv
// instr_loader: program loader and instruction encoder for the Zepto core.
//
// Accepts decoded instruction fields over a valid/ready stream.
// Packs each tuple into a 32-bit word laid out as {imm, rb, ra, rd, op}.
// Writes the words sequentially into instruction memory, starting at address 0.
//
// Optional feature (compile-time macro LOADER_OPCHECK_EN):
//   defined   - illegal opcodes are not written; err/err_op report the first one.
//   undefined - every opcode is written; err and err_op are tied to 0.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   start_i           one-cycle pulse; begins or restarts a load session
//   in_valid_i        field tuple present
//   in_ready_o        tuple accepted this cycle when valid
//   in_last_i         final instruction of the program
//   in_op_i, in_rd_i, in_ra_i, in_rb_i, in_imm_i
//                     decoded instruction fields
//   mem_we_o          write strobe (one cycle per written word)
//   mem_addr_o        write address
//   mem_wdata_o       encoded word
//   busy_o            session in progress
//   done_o            one-cycle pulse at the end of a session
//   count_o           words written this session
//   err_o, err_op_o   sticky illegal-opcode flag; opcode of the first illegal tuple
//   ovf_o             sticky: memory filled before in_last
module instr_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    input  logic [3:0]        in_op_i,
    input  logic [3:0]        in_rd_i,
    input  logic [3:0]        in_ra_i,
    input  logic [3:0]        in_rb_i,
    input  logic [15:0]       in_imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic              err_o,
    output logic [3:0]        err_op_o,
    output logic              ovf_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d, count_inc;
    logic                ovf_q, ovf_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                full, accept, op_legal, err_set;

    // count never exceeds DEPTH, so its top bit is set exactly when the memory is full.
    assign full       = count_q[ADDR_W];
    assign count_inc  = count_q + {{ADDR_W{1'b0}}, 1'b1};
    assign busy_o     = (state_q == StLoad);
    assign done_o     = (state_q == StDone);
    assign in_ready_o = busy_o && !full;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_set     = 1'b0;

        case (state_q)
            StIdle: ;
            StLoad: begin
                if (accept) begin
                    if (op_legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = {in_imm_i, in_rb_i, in_ra_i, in_rd_i, in_op_i};
                        count_d     = count_inc;
                    end else begin
                        err_set = 1'b1;
                    end
                    if (in_last_i) begin
                        state_d = StDone;
                    end else if (op_legal && count_inc[ADDR_W]) begin
                        // Memory just filled and the program is not finished.
                        ovf_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // start overrides everything, including a beat accepted on the same edge.
        if (start_i) begin
            state_d  = StLoad;
            count_d  = '0;
            ovf_d    = 1'b0;
            mem_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;

`ifdef LOADER_OPCHECK_EN
    logic       err_q, err_d;
    logic [3:0] err_op_q, err_op_d;

    // Legal: 0000-0111, 1001, 1011, 1100.
    assign op_legal = !in_op_i[3] || (in_op_i == 4'b1001) || (in_op_i == 4'b1011) ||
                      (in_op_i == 4'b1100);

    always_comb begin
        err_d    = err_q;
        err_op_d = err_op_q;
        if (start_i) begin
            err_d    = 1'b0;
            err_op_d = 4'h0;
        end else if (err_set) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_op_d = in_op_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q    <= 1'b0;
            err_op_q <= 4'h0;
        end else begin
            err_q    <= err_d;
            err_op_q <= err_op_d;
        end
    end

    assign err_o    = err_q;
    assign err_op_o = err_op_q;
`else
    logic unused_err_set;

    assign op_legal       = 1'b1;
    assign unused_err_set = err_set;
    assign err_o          = 1'b0;
    assign err_op_o       = 4'h0;
`endif

endmodule
